// File: rtl/lcd_write_engine.sv
`default_nettype none
// ============================================================================
//  Module      : lcd_write_engine
//  Description : Write-only strobe engine for HD44780-class character LCDs.
//                Runs one timed write per accepted request in 8-bit or 4-bit
//                bus mode: setup, E pulse, hold (twice for 4-bit), then an
//                execution wait. Clear/home commands (0x01..0x03) get the
//                long execution wait.
//                Optional macro LCD_PENDING_EN adds a one-entry pending slot
//                so that a request arriving while busy runs straight after
//                the current one.
//  Revision    : 1.0 - initial release
// ============================================================================
module lcd_write_engine #(
  parameter int BUS_WIDTH     = 8,
  parameter int SETUP_CYC     = 2,
  parameter int E_WIDTH       = 12,
  parameter int HOLD_CYC      = 2,
  parameter int EXEC_CYC      = 40,
  parameter int LONG_EXEC_CYC = 1600
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 RS,
  input  logic [7:0]           data,
  output logic                 busy,
  output logic                 done,
  output logic                 LCD_RS,
  output logic                 LCD_RW,
  output logic                 LCD_E,
  output logic [BUS_WIDTH-1:0] LCD_data
);

  // Counter is sized for the largest timed interval.
  localparam int c_MAX_A   = (SETUP_CYC > E_WIDTH) ? SETUP_CYC : E_WIDTH;
  localparam int c_MAX_B   = (HOLD_CYC > EXEC_CYC) ? HOLD_CYC : EXEC_CYC;
  localparam int c_MAX_C   = (c_MAX_A > c_MAX_B) ? c_MAX_A : c_MAX_B;
  localparam int c_MAX_CYC = (c_MAX_C > LONG_EXEC_CYC) ? c_MAX_C : LONG_EXEC_CYC;
  localparam int c_CNT_W   = $clog2(c_MAX_CYC + 1);

  localparam logic [c_CNT_W-1:0] c_SETUP_LD = c_CNT_W'(SETUP_CYC - 1);
  localparam logic [c_CNT_W-1:0] c_E_LD     = c_CNT_W'(E_WIDTH - 1);
  localparam logic [c_CNT_W-1:0] c_HOLD_LD  = c_CNT_W'(HOLD_CYC - 1);
  localparam logic [c_CNT_W-1:0] c_EXEC_LD  = c_CNT_W'(EXEC_CYC - 1);
  localparam logic [c_CNT_W-1:0] c_LONG_LD  = c_CNT_W'(LONG_EXEC_CYC - 1);
  localparam bit                 c_NIBBLE   = (BUS_WIDTH == 4);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SETUP = 3'd1,
    S_PULSE = 3'd2,
    S_HOLD  = 3'd3,
    S_EXEC  = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t                 r_state;
  logic [c_CNT_W-1:0]     r_cnt;
  logic                   r_long;
  logic                   r_second;
  logic [BUS_WIDTH-1:0]   r_second_bus;
  logic                   r_busy;
  logic                   r_done;
  logic                   r_lcd_rs;
  logic                   r_lcd_e;
  logic [BUS_WIDTH-1:0]   r_lcd_data;

  // Source of the request being accepted (live inputs or pending slot).
  logic                   w_src_rs;
  logic [7:0]             w_src_data;
  logic                   w_src_long;
  logic [BUS_WIDTH-1:0]   w_src_first;
  logic [BUS_WIDTH-1:0]   w_src_second;
  logic                   w_accept;

`ifdef LCD_PENDING_EN
  logic                   r_pend_valid;
  logic                   r_pend_rs;
  logic [7:0]             r_pend_data;
  logic                   w_use_pend;

  // A pending entry always wins over a fresh start in the DONE cycle.
  assign w_use_pend = (r_state == S_DONE) && r_pend_valid;
  assign w_src_rs   = w_use_pend ? r_pend_rs   : RS;
  assign w_src_data = w_use_pend ? r_pend_data : data;
  assign w_accept   = ((r_state == S_IDLE) || (r_state == S_DONE)) &&
                      (start || w_use_pend);

  // Capture one request while busy; consume it in DONE; drop extras.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pend_valid <= 1'b0;
      r_pend_rs    <= 1'b0;
      r_pend_data  <= 8'h00;
    end else if (w_use_pend) begin
      r_pend_valid <= 1'b0;
    end else if (start && !r_pend_valid &&
                 (r_state != S_IDLE) && (r_state != S_DONE)) begin
      r_pend_valid <= 1'b1;
      r_pend_rs    <= RS;
      r_pend_data  <= data;
    end
  end
`else
  assign w_src_rs   = RS;
  assign w_src_data = data;
  assign w_accept   = (r_state == S_IDLE) && start;
`endif

  // Clear (0x01) and home (0x02/0x03) commands need the long execution wait.
  assign w_src_long = !w_src_rs && (w_src_data[7:2] == 6'd0) && (w_src_data != 8'h00);

  generate
    if (BUS_WIDTH == 4) begin : g_bus4
      assign w_src_first  = w_src_data[7:4];
      assign w_src_second = w_src_data[3:0];
    end else begin : g_bus8
      assign w_src_first  = w_src_data;
      assign w_src_second = w_src_data;
    end
  endgenerate

  // Sequencer: state, interval counter and registered pin values.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_long       <= 1'b0;
      r_second     <= 1'b0;
      r_second_bus <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_lcd_rs     <= 1'b0;
      r_lcd_e      <= 1'b0;
      r_lcd_data   <= '0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          r_done <= 1'b0;
          if (w_accept) begin
            r_state      <= S_SETUP;
            r_cnt        <= c_SETUP_LD;
            r_busy       <= 1'b1;
            r_long       <= w_src_long;
            r_second     <= 1'b0;
            r_second_bus <= w_src_second;
            r_lcd_rs     <= w_src_rs;
            r_lcd_data   <= w_src_first;
          end else begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
        end
        S_SETUP: begin
          if (r_cnt == '0) begin
            r_state <= S_PULSE;
            r_cnt   <= c_E_LD;
            r_lcd_e <= 1'b1;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        S_PULSE: begin
          if (r_cnt == '0) begin
            r_state <= S_HOLD;
            r_cnt   <= c_HOLD_LD;
            r_lcd_e <= 1'b0;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        S_HOLD: begin
          if (r_cnt == '0) begin
            if (c_NIBBLE && !r_second) begin
              // Low nibble goes out on a second setup/pulse/hold pass.
              r_state    <= S_SETUP;
              r_cnt      <= c_SETUP_LD;
              r_second   <= 1'b1;
              r_lcd_data <= r_second_bus;
            end else begin
              r_state    <= S_EXEC;
              r_cnt      <= r_long ? c_LONG_LD : c_EXEC_LD;
              r_lcd_rs   <= 1'b0;
              r_lcd_data <= '0;
            end
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        S_EXEC: begin
          if (r_cnt == '0) begin
            r_state <= S_DONE;
            r_done  <= 1'b1;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        default: begin
          r_state    <= S_IDLE;
          r_cnt      <= '0;
          r_busy     <= 1'b0;
          r_done     <= 1'b0;
          r_lcd_rs   <= 1'b0;
          r_lcd_e    <= 1'b0;
          r_lcd_data <= '0;
        end
      endcase
    end
  end

  assign busy     = r_busy;
  assign done     = r_done;
  assign LCD_RS   = r_lcd_rs;
  assign LCD_RW   = 1'b0;
  assign LCD_E    = r_lcd_e;
  assign LCD_data = r_lcd_data;

endmodule
`default_nettype wire
